// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU core and its program store:
// the instruction format, the opcodes, and the load-state encoding.
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W  = 10;
  localparam int OPCODE_W = 6;
  localparam int ARG_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LDI   = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_XOR   = 6'h06;
  localparam logic [OPCODE_W-1:0] OP_OUT   = 6'h07;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_JZ    = 6'h09;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'h3F;

  // A NOP with a zero argument: what the core sees for any address without a program word.
  localparam logic [INSTR_W-1:0] FILL_DEFAULT = {OP_NOP, {ARG_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } load_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_ram.sv
// DEPTH x DATA_W program memory: one synchronous write port, one asynchronous read port.
`default_nettype none

module prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // No reset: stale contents are masked by the program length upstream.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/program_store_fetch.sv
// Instruction store ahead of the 4-bit core: loads a program over valid/ready,
// releases the core with cpu_run, and serves its combinational fetch.
`default_nettype none

module program_store_fetch
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W     = 4,
  parameter int                 INSTR_W    = cpu_pkg::INSTR_W,
  parameter int                 DEPTH      = 2**ADDR_W,
  parameter logic [INSTR_W-1:0] FILL_INSTR = FILL_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               reload,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] statement,
  output logic               cpu_run,
  output logic [ADDR_W:0]    prog_len,
  output logic               load_err
);

  load_state_t       state, state_d;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_d;
  logic              cpu_run_d;
  logic              load_err_d;
  logic              xfer;
  logic              wr_en;
  logic [INSTR_W-1:0] rd_data;

  assign load_ready = reset_n && ((state == IDLE) || (state == LOAD));
  assign xfer       = load_valid && load_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      prog_len <= '0;
      cpu_run  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_d;
      wr_ptr   <= wr_ptr_d;
      prog_len <= prog_len_d;
      cpu_run  <= cpu_run_d;
      load_err <= load_err_d;
    end
  end

  always_comb begin
    state_d    = state;
    wr_ptr_d   = wr_ptr;
    prog_len_d = prog_len;
    cpu_run_d  = cpu_run;
    load_err_d = load_err;
    wr_en      = 1'b0;

    // reload outranks a simultaneous handshake: the word is accepted but dropped.
    // In IDLE everything is already clear, so this is harmless there.
    if (reload) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      prog_len_d = '0;
      cpu_run_d  = 1'b0;
      load_err_d = 1'b0;
    end else if (xfer) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr + 1'b1;
      if (load_last) begin
        state_d    = RUN;
        prog_len_d = {1'b0, wr_ptr} + (ADDR_W+1)'(1);
        cpu_run_d  = 1'b1;
      end else if (wr_ptr == {ADDR_W{1'b1}}) begin
        state_d    = ERR;
        wr_ptr_d   = wr_ptr;
        load_err_d = 1'b1;
      end else begin
        state_d = LOAD;
      end
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W),
    .DEPTH  (DEPTH)
  ) u_prog_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  assign statement = ((state == RUN) && ({1'b0, pc} < prog_len)) ? rd_data : FILL_INSTR;

endmodule

`default_nettype wire
